// File: rtl/divseq_if.sv
// Handshake and operand bundle between the microcode sequencer and the divider.
// The master side starts a divide; the slave side is the divider itself.
interface divseq_if;
   logic        start;
   logic [31:0] x;
   logic [15:0] y;
   logic        is_signed;
   logic        word_op;
   logic        busy;
   logic        done;
   logic [31:0] out;
   logic        div_err;

   modport master (
      output start, x, y, is_signed, word_op,
      input  busy, done, out, div_err
   );

   modport slave (
      input  start, x, y, is_signed, word_op,
      output busy, done, out, div_err
   );
endinterface

// File: rtl/divseq.sv
// Multi-cycle restoring divider for DIV/IDIV; one quotient bit per clock.
// Define DIV_SIGNED_EN to support IDIV; otherwise every divide is unsigned.
module divseq #(
   parameter int unsigned NEG_MAX_ERR = 1
) (
   input logic     clk,
   input logic     rst_n,
   divseq_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StErr} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        word_q;
   logic        sgn_q;
   logic        qneg_q;
   logic        rneg_q;
   logic [15:0] ymag_q;
   logic [15:0] rem_q;
   logic [15:0] dl_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] out_q;

   logic op_signed;
`ifdef DIV_SIGNED_EN
   assign op_signed = bus.is_signed;
`else
   assign op_signed = 1'b0;
`endif

   // Operand setup, evaluated against the live inputs at the start edge.
   logic        sx;
   logic        sy;
   logic [31:0] xm32;
   logic [15:0] x16;
   logic [15:0] xm16;
   logic [7:0]  ym8;
   logic [15:0] ymag;
   logic [15:0] hi;
   logic [15:0] lo;
   logic        early_err;

   always_comb begin
      x16  = bus.x[15:0];
      sx   = op_signed & (bus.word_op ? bus.x[31] : bus.x[15]);
      sy   = op_signed & (bus.word_op ? bus.y[15] : bus.y[7]);
      xm32 = sx ? (32'd0 - bus.x) : bus.x;
      xm16 = sx ? (16'd0 - x16) : x16;
      ym8  = sy ? (8'd0 - bus.y[7:0]) : bus.y[7:0];
      if (bus.word_op) begin
         ymag = sy ? (16'd0 - bus.y) : bus.y;
         hi   = xm32[31:16];
         lo   = xm32[15:0];
      end else begin
         // Byte low half is left-aligned so the next dividend bit is always dl_q[15].
         ymag = {8'd0, ym8};
         hi   = {8'd0, xm16[15:8]};
         lo   = {xm16[7:0], 8'd0};
      end
      early_err = (ymag == 16'd0) || (hi >= ymag);
   end

   // One restoring step: the remainder always fits 16 bits after a subtract.
   logic [16:0] sh;
   logic        ge;
   logic [15:0] sub;

   always_comb begin
      sh  = {rem_q, dl_q[15]};
      ge  = (sh >= {1'b0, ymag_q});
      sub = sh[15:0] - ymag_q;
   end

   // Sign fix-up and signed range check.
   logic [15:0] q;
   logic [15:0] r;
   logic [15:0] quot_s;
   logic [15:0] rem_s;
   logic [15:0] lim_pos;
   logic [15:0] lim_neg;
   logic        ovf;
   logic [31:0] fix_out;

   always_comb begin
      q       = word_q ? dl_q : {8'd0, dl_q[7:0]};
      r       = word_q ? rem_q : {8'd0, rem_q[7:0]};
      quot_s  = qneg_q ? (16'd0 - q) : q;
      rem_s   = rneg_q ? (16'd0 - r) : r;
      lim_pos = word_q ? 16'h7fff : 16'h007f;
      lim_neg = (word_q ? 16'h8000 : 16'h0080) - ((NEG_MAX_ERR != 0) ? 16'd1 : 16'd0);
      ovf     = sgn_q & (qneg_q ? (q > lim_neg) : (q > lim_pos));
      fix_out = word_q ? {rem_s, quot_s} : {16'd0, rem_s[7:0], quot_s[7:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         word_q  <= 1'b0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         ymag_q  <= 16'd0;
         rem_q   <= 16'd0;
         dl_q    <= 16'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         out_q   <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  busy_q  <= 1'b1;
                  word_q  <= bus.word_op;
                  sgn_q   <= op_signed;
                  qneg_q  <= sx ^ sy;
                  rneg_q  <= sx;
                  ymag_q  <= ymag;
                  rem_q   <= hi;
                  dl_q    <= lo;
                  cnt_q   <= bus.word_op ? 4'd15 : 4'd7;
                  state_q <= early_err ? StErr : StCalc;
               end
            end
            StCalc: begin
               rem_q <= ge ? sub : sh[15:0];
               dl_q  <= {dl_q[14:0], ge};
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd0) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               out_q   <= ovf ? 32'd0 : fix_out;
               err_q   <= ovf;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            StErr: begin
               out_q   <= 32'd0;
               err_q   <= 1'b1;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.out     = out_q;
   assign bus.div_err = err_q;

endmodule

// File: tb/tb_divseq.sv
// Bench for divseq: directed vector table, control corner cases, and random
// divides checked against an arithmetic reference model.
module tb_divseq;

   localparam int unsigned NegMaxErr = 1;
`ifdef DIV_SIGNED_EN
   localparam bit SignedEn = 1'b1;
`else
   localparam bit SignedEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   divseq_if bus ();

   divseq #(.NEG_MAX_ERR(NegMaxErr)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [15:0] y;
      bit          sgn;
      bit          word;
      logic [31:0] out;
      bit          err;
      bit          chk_out;
      int          lat;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero as the 8086 does.
   function automatic void model(input logic [31:0] x, input logic [15:0] y, input bit sgn,
                                 input bit word, output logic [31:0] o, output bit err,
                                 output bit early);
      longint a, b, qq, rr, aq, lim;
      int n;
      bit s;
      logic signed [31:0] xs32;
      logic signed [15:0] xs16;
      logic signed [15:0] ys16;
      logic signed [7:0]  ys8;
      n = word ? 16 : 8;
      s = sgn && SignedEn;
      xs32 = x;
      xs16 = x[15:0];
      ys16 = y;
      ys8  = y[7:0];
      if (word) begin
         if (s) begin a = longint'(xs32); b = longint'(ys16); end
         else   begin a = longint'(x);    b = longint'(y);    end
      end else begin
         if (s) begin a = longint'(xs16);     b = longint'(ys8);     end
         else   begin a = longint'(x[15:0]); b = longint'(y[7:0]); end
      end
      o = 32'd0;
      err = 1'b0;
      early = 1'b0;
      if (b == 0) begin
         err = 1'b1;
         early = 1'b1;
         return;
      end
      qq = a / b;
      rr = a % b;
      aq = (qq < 0) ? -qq : qq;
      if (aq >= (longint'(1) << n)) begin
         err = 1'b1;
         early = 1'b1;
         return;
      end
      if (s) begin
         lim = longint'(1) << (n - 1);
         if (qq > lim - 1 || qq < -(lim - longint'(NegMaxErr))) begin
            err = 1'b1;
            return;
         end
      end
      if (word) o = {rr[15:0], qq[15:0]};
      else      o = {16'd0, rr[7:0], qq[7:0]};
   endfunction

   // Starts one divide from mid-cycle and checks latency, result and busy/done shape.
   task automatic check_div(input string tag, input logic [31:0] x, input logic [15:0] y,
                            input bit sgn, input bit word, input logic [31:0] exp_out,
                            input bit exp_err, input bit chk_out, input int exp_lat,
                            input bit hold_chk);
      int lat;
      bus.x = x;
      bus.y = y;
      bus.is_signed = sgn;
      bus.word_op = word;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x = $urandom;
      bus.y = 16'($urandom);
      bus.is_signed = 1'($urandom);
      bus.word_op = 1'($urandom);
      chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
      lat = 1;
      while (!bus.done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_div_err"}, 32'(bus.div_err), 32'(exp_err));
      if (chk_out) chk({tag, "_out"}, bus.out, exp_out);
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      if (hold_chk) begin
         @(posedge clk);
         #1;
         chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
         chk({tag, "_err_hold"}, 32'(bus.div_err), 32'(exp_err));
         if (chk_out) chk({tag, "_out_hold"}, bus.out, exp_out);
      end
   endtask

   initial begin
      logic [31:0] rx, mo;
      logic [15:0] ry;
      bit rs, rw, me, mearly;
      int lat, nd;

      bus.start = 1'b0;
      bus.x = 32'd0;
      bus.y = 16'd0;
      bus.is_signed = 1'b0;
      bus.word_op = 1'b0;

      tbl[0]  = '{32'h00010005, 16'h0003, 1'b0, 1'b1, 32'h00005557, 1'b0, 1'b1, 18};
      tbl[1]  = '{32'habcd0064, 16'h5507, 1'b0, 1'b0, 32'h0000020e, 1'b0, 1'b1, 10};
      tbl[2]  = '{32'h00001234, 16'h0000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 2};
      tbl[3]  = '{32'h00001234, 16'hff00, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 2};
      tbl[4]  = '{32'h00030000, 16'h0003, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 2};
      tbl[5]  = '{32'h00000000, 16'h0005, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 18};
      tbl[6]  = '{32'hfffeffff, 16'hffff, 1'b0, 1'b1, 32'hfffeffff, 1'b0, 1'b1, 18};
`ifdef DIV_SIGNED_EN
      tbl[7]  = '{32'h00008000, 16'h0001, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 18};
      tbl[8]  = '{32'h0000ff80, 16'h0001, 1'b1, 1'b0, 32'h00000000, NegMaxErr != 0, 1'b0, 10};
      tbl[9]  = '{32'hfffffff9, 16'h0002, 1'b1, 1'b1, 32'hfffffffd, 1'b0, 1'b1, 18};
      tbl[10] = '{32'h00000007, 16'h00fe, 1'b1, 1'b0, 32'h000001fd, 1'b0, 1'b1, 10};
      tbl[11] = '{32'h0000ff81, 16'h0001, 1'b1, 1'b0, 32'h00000081, 1'b0, 1'b1, 10};
`else
      tbl[7]  = '{32'h00008000, 16'h0001, 1'b1, 1'b1, 32'h00008000, 1'b0, 1'b1, 18};
      tbl[8]  = '{32'h0000ff80, 16'h0001, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 2};
      tbl[9]  = '{32'hfffffff9, 16'h0002, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 2};
      tbl[10] = '{32'h00000007, 16'h00fe, 1'b1, 1'b0, 32'h00000700, 1'b0, 1'b1, 10};
      tbl[11] = '{32'h0000ff81, 16'h0001, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 2};
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_err", 32'(bus.div_err), 32'd0);
      chk("reset_out", bus.out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         check_div($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].sgn, tbl[i].word,
                   tbl[i].out, tbl[i].err, tbl[i].chk_out, tbl[i].lat, 1'b1);
      end

      // start pulsed mid-CALC must be ignored and not queued
      bus.x = 32'h00010005;
      bus.y = 16'h0003;
      bus.is_signed = 1'b0;
      bus.word_op = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 1;
      repeat (4) begin @(posedge clk); #1; lat++; end
      bus.x = 32'd0;
      bus.y = 16'd0;
      bus.word_op = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      lat++;
      bus.start = 1'b0;
      while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
      chk("midcalc_latency", lat, 18);
      chk("midcalc_out", bus.out, 32'h00005557);
      chk("midcalc_err", 32'(bus.div_err), 32'd0);
      nd = 0;
      repeat (25) begin @(posedge clk); #1; if (bus.done) nd++; end
      chk("midcalc_no_extra_done", nd, 0);

      // Reset at CALC cycle 5 aborts silently
      bus.x = 32'h00010005;
      bus.y = 16'h0003;
      bus.word_op = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_out", bus.out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (25) begin @(posedge clk); #1; if (bus.done) nd++; end
      chk("abort_no_done", nd, 0);
      check_div("after_abort", 32'h00000064, 16'h0007, 1'b0, 1'b0, 32'h0000020e, 1'b0, 1'b1,
                10, 1'b1);

      // Back-to-back: second start lands in the done cycle of the first
      check_div("b2b_first", 32'h00010005, 16'h0003, 1'b0, 1'b1, 32'h00005557, 1'b0, 1'b1,
                18, 1'b0);
      check_div("b2b_second", 32'h00000064, 16'h0007, 1'b0, 1'b0, 32'h0000020e, 1'b0, 1'b1,
                10, 1'b1);

      // Random divides against the reference model
      for (int i = 0; i < 200; i++) begin
         rx = $urandom;
         ry = 16'($urandom);
         rs = 1'($urandom);
         rw = 1'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            if (rw) begin
               if (ry == 16'd0) ry = 16'd1;
               rx[31:16] = 16'($urandom_range(0, int'(ry) - 1));
            end else begin
               if (ry[7:0] == 8'd0) ry[7:0] = 8'd1;
               rx[15:8] = 8'($urandom_range(0, int'(ry[7:0]) - 1));
            end
         end
         if ($urandom_range(0, 15) == 0) rx = 32'd0;
         model(rx, ry, rs, rw, mo, me, mearly);
         check_div($sformatf("rnd%0d", i), rx, ry, rs, rw, mo, me, !me || mearly,
                   mearly ? 2 : (rw ? 18 : 10), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
